// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data sides, data side first.
// Optional wait-state abort is compiled in by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_ack,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ack,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  busy,
   output logic                  err
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT_CYCLES out of range 1..65535");
   end

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;       // 1 = data side owns the port
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  i_ack_q, i_ack_d;
   logic                  d_ack_q, d_ack_d;
   logic                  busy_q, busy_d;
`ifdef ARB_TIMEOUT_EN
   logic [15:0]           wait_q, wait_d;
   logic                  err_q, err_d;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      busy_d      = busy_q;
`ifdef ARB_TIMEOUT_EN
      wait_d      = wait_q;
      err_d       = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (d_req) begin
               owner_d     = 1'b1;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_we_d    = d_we;
               mem_req_d   = 1'b1;
               busy_d      = 1'b1;
               state_d     = BUSY;
`ifdef ARB_TIMEOUT_EN
               wait_d      = 16'd0;
`endif
            end else if (i_req) begin
               owner_d    = 1'b0;
               mem_addr_d = i_addr;
               mem_we_d   = 1'b0;
               mem_req_d  = 1'b1;
               busy_d     = 1'b1;
               state_d    = BUSY;
`ifdef ARB_TIMEOUT_EN
               wait_d     = 16'd0;
`endif
            end
         end
         BUSY: begin
            if (mem_ready) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = RESP;
               if (owner_q) begin
                  d_ack_d = 1'b1;
                  if (!mem_we_q) d_rdata_d = mem_rdata;
               end else begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = mem_rdata;
               end
`ifdef ARB_TIMEOUT_EN
            end else if (wait_q == 16'(TIMEOUT_CYCLES)) begin
               // Abort: ack the owner with err and zeroed read data
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = RESP;
               err_d     = 1'b1;
               if (owner_q) begin
                  d_ack_d = 1'b1;
                  if (!mem_we_q) d_rdata_d = '0;
               end else begin
                  i_ack_d   = 1'b1;
                  i_rdata_d = '0;
               end
            end else begin
               wait_d = wait_q + 16'd1;
`endif
            end
         end
         RESP: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         wait_q      <= 16'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         busy_q      <= busy_d;
`ifdef ARB_TIMEOUT_EN
         wait_q      <= wait_d;
         err_q       <= err_d;
`endif
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed test-plan steps plus randomized transactions,
// checked cycle by cycle against a transaction-level timeline model.
module tb_mem_port_arbiter;

   localparam int unsigned TO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we, mem_ready;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_ack, d_ack, mem_req, mem_we, busy, err;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_i_rdata, exp_d_rdata;

   mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy(busy), .err(err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction from an IDLE negedge: grant, BUSY with `waits` wait states, RESP, IDLE.
   task automatic serve(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
      int busy_cycles;
      bit tmo;
      tmo         = 1'b0;
      busy_cycles = waits + 1;
`ifdef ARB_TIMEOUT_EN
      if (waits > int'(TO)) begin
         tmo         = 1'b1;
         busy_cycles = int'(TO) + 1;
      end
`endif
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      @(posedge clock);
      for (int k = 0; k < busy_cycles; k++) begin
         @(negedge clock);
         chk("busy_mem_req", 32'(mem_req), 32'd1);
         chk("busy_addr", mem_addr, addr);
         chk("busy_we", 32'(mem_we), 32'(is_d && we));
         if (is_d) chk("busy_wdata", mem_wdata, wdata);
         chk("busy_flag", 32'(busy), 32'd1);
         chk("busy_acks", 32'({i_ack, d_ack, err}), 32'd0);
         mem_ready = (k == waits);
         mem_rdata = (k == waits) ? rdata : $urandom();
         if (is_d) begin
            d_addr = $urandom(); d_wdata = $urandom();
         end else begin
            i_addr = $urandom();
         end
      end
      @(negedge clock);
      if (is_d) begin
         if (!we) exp_d_rdata = tmo ? 32'd0 : rdata;
      end else begin
         exp_i_rdata = tmo ? 32'd0 : rdata;
      end
      chk("resp_i_ack", 32'(i_ack), 32'(!is_d));
      chk("resp_d_ack", 32'(d_ack), 32'(is_d));
      chk("resp_err", 32'(err), 32'(tmo));
      chk("resp_mem_req", 32'({mem_req, mem_we}), 32'd0);
      chk("resp_busy", 32'(busy), 32'd1);
      chk("resp_i_rdata", i_rdata, exp_i_rdata);
      chk("resp_d_rdata", d_rdata, exp_d_rdata);
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom();
      if (is_d) d_req = 1'b0; else i_req = 1'b0;
      @(negedge clock);
      chk("idle_busy", 32'({busy, mem_req}), 32'd0);
      chk("idle_acks", 32'({i_ack, d_ack, err}), 32'd0);
      chk("idle_i_rdata", i_rdata, exp_i_rdata);
      chk("idle_d_rdata", d_rdata, exp_d_rdata);
      mem_ready = 1'b0;
   endtask

   initial begin
      int mode, w1, w2;
      reset = 1'b1;
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      exp_i_rdata = '0; exp_d_rdata = '0;
      repeat (2) @(negedge clock);
      chk("rst_ctrl", 32'({mem_req, mem_we, i_ack, d_ack, busy, err}), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", i_rdata | d_rdata, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Zero-wait fetch
      serve(1'b0, 1'b0, 32'h0040_0000, 32'd0, 32'h8C08_0004, 0);
      // Simultaneous requests: data first, fetch from the following IDLE
      i_req = 1'b1; i_addr = 32'h0040_0010;
      serve(1'b1, 1'b0, 32'h1001_0000, 32'd0, 32'h1234_5678, 0);
      serve(1'b0, 1'b0, 32'h0040_0010, 32'd0, 32'hA5A5_5A5A, 1);
      // Store with three wait states leaves d_rdata alone
      serve(1'b1, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3);

      // Reset in the middle of a fetch
      i_req = 1'b1; i_addr = 32'h0040_0020; mem_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      exp_i_rdata = '0; exp_d_rdata = '0;
      chk("midrst_ctrl", 32'({mem_req, busy, i_ack, d_ack}), 32'd0);
      chk("midrst_rdata", i_rdata | d_rdata, 32'd0);
      @(negedge clock);
      chk("midrst_no_ack", 32'(i_ack), 32'd0);
      reset = 1'b0;
      serve(1'b0, 1'b0, 32'h0040_0020, 32'd0, 32'h2222_3333, 2);

`ifdef ARB_TIMEOUT_EN
      serve(1'b1, 1'b0, 32'h1001_0010, 32'd0, 32'h4444_5555, int'(TO) + 3);
      serve(1'b1, 1'b0, 32'h1001_0014, 32'd0, 32'h6666_7777, int'(TO));
`endif

      // Randomized transactions
      for (int n = 0; n < 40; n++) begin
         mode = int'($urandom_range(0, 3));
         w1   = int'($urandom_range(0, 6));
         w2   = int'($urandom_range(0, 6));
         case (mode)
            0: serve(1'b0, 1'b0, $urandom(), 32'd0, $urandom(), w1);
            1: serve(1'b1, 1'b0, $urandom(), $urandom(), $urandom(), w1);
            2: serve(1'b1, 1'b1, $urandom(), $urandom(), $urandom(), w1);
            default: begin
               i_req = 1'b1; i_addr = $urandom();
               serve(1'b1, 1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), w1);
               serve(1'b0, 1'b0, $urandom(), 32'd0, $urandom(), w2);
            end
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
